// File: rtl/imm_decode_ctrl_if.sv
// Handshake bundle for the immediate decoder: upstream instruction channel
// plus the downstream decoded-entry channel.
interface imm_decode_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm;
    logic [1:0]  imm_sel;
    logic [4:0]  opcode_out;
    logic        illegal;

    // Decoder-side view
    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, imm, imm_sel, opcode_out, illegal
    );

    // Producer/consumer-side view
    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, imm, imm_sel, opcode_out, illegal
    );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Immediate decoder with a two-entry (head + skid) output buffer.
// Decode happens on accept; all outputs come from the registered head entry.
module imm_decode_ctrl #(
    parameter bit ILLEGAL_ZERO = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    imm_decode_ctrl_if.slave        bus,
    output logic [7:0]              illegal_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;

    logic [31:0] head_imm,  skid_imm;
    logic [1:0]  head_sel,  skid_sel;
    logic [4:0]  head_opc,  skid_opc;
    logic        head_ill,  skid_ill;

    logic        accept;
    logic        fire;

    logic [4:0]  dec_opc;
    logic [1:0]  dec_sel;
    logic        dec_ill;
    logic [31:0] dec_ext;
    logic [31:0] dec_imm;

    assign bus.out_valid = (state != ST_EMPTY);
    assign bus.in_ready  = (state != ST_TWO);

    assign accept = bus.in_valid & bus.in_ready;
    assign fire   = bus.out_valid & bus.out_ready;

    assign dec_opc = bus.instr[31:27];
    assign dec_sel = dec_opc[4:3];
    assign dec_ill = (dec_opc[4:2] == 3'b111);

    always_comb begin
        dec_ext = '0;
        case (dec_sel)
            2'b00:   dec_ext = {17'b0, bus.instr[26:12]};
            2'b01:   dec_ext = {13'b0, bus.instr[26:8]};
            2'b10:   dec_ext = {9'b0,  bus.instr[26:4]};
            default: dec_ext = {5'b0,  bus.instr[26:0]};
        endcase
    end

    assign dec_imm = (dec_ill && ILLEGAL_ZERO) ? 32'h0 : dec_ext;

    // Flush wins over everything; TWO never accepts because in_ready is low there.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_nxt = ST_ONE;
                ST_ONE: begin
                    if (accept && !fire)      state_nxt = ST_TWO;
                    else if (fire && !accept) state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (fire) state_nxt = ST_ONE;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_imm <= '0;
            head_sel <= '0;
            head_opc <= '0;
            head_ill <= 1'b0;
            skid_imm <= '0;
            skid_sel <= '0;
            skid_opc <= '0;
            skid_ill <= 1'b0;
        end else if (!flush) begin
            if ((state == ST_EMPTY && accept) || (state == ST_ONE && accept && fire)) begin
                head_imm <= dec_imm;
                head_sel <= dec_sel;
                head_opc <= dec_opc;
                head_ill <= dec_ill;
            end else if (state == ST_TWO && fire) begin
                head_imm <= skid_imm;
                head_sel <= skid_sel;
                head_opc <= skid_opc;
                head_ill <= skid_ill;
            end
            if (state == ST_ONE && accept && !fire) begin
                skid_imm <= dec_imm;
                skid_sel <= dec_sel;
                skid_opc <= dec_opc;
                skid_ill <= dec_ill;
            end
        end
    end

    // Counts only accepts that survive; flush does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_cnt <= 8'h00;
        end else if (accept && dec_ill && !flush && illegal_cnt != 8'hFF) begin
            illegal_cnt <= illegal_cnt + 8'h01;
        end
    end

    assign bus.imm        = head_imm;
    assign bus.imm_sel    = head_sel;
    assign bus.opcode_out = head_opc;
    assign bus.illegal    = head_ill;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Randomized and directed checks of imm_decode_ctrl against a queue-based
// model that stores raw instructions and derives expected fields arithmetically.
module tb_imm_decode_ctrl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] illegal_cnt;

    imm_decode_ctrl_if bus();

    imm_decode_ctrl #(.ILLEGAL_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          testCount = 0;
    int          failCount = 0;
    logic [31:0] modelQ[$];
    int          modelCnt = 0;

    function automatic logic isIllegal(input logic [31:0] ins);
        return (ins[31:27] >= 5'd28);
    endfunction

    // Field width is 15 + 4*sel bits taken from the top of the payload.
    function automatic logic [31:0] expImm(input logic [31:0] ins);
        int          s;
        logic [31:0] payload;
        if (isIllegal(ins)) return 32'h0;
        s       = int'(ins[31:30]);
        payload = {5'b0, ins[26:0]};
        return payload >> (12 - 4 * s);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compareModel();
        logic [31:0] h;
        checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, modelQ.size() != 0});
        checkOutput("in_ready", {31'b0, bus.in_ready}, {31'b0, modelQ.size() < 2});
        checkOutput("illegal_cnt", {24'b0, illegal_cnt}, 32'(modelCnt));
        if (modelQ.size() != 0) begin
            h = modelQ[0];
            checkOutput("imm", bus.imm, expImm(h));
            checkOutput("imm_sel", {30'b0, bus.imm_sel}, {30'b0, h[31:30]});
            checkOutput("opcode_out", {27'b0, bus.opcode_out}, {27'b0, h[31:27]});
            checkOutput("illegal", {31'b0, bus.illegal}, {31'b0, isIllegal(h)});
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        logic acc;
        logic fir;
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.out_ready = ordy;
        flush         = fl;
        acc = iv && (modelQ.size() < 2);
        fir = ordy && (modelQ.size() != 0);
        @(posedge clk);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (fir) void'(modelQ.pop_front());
            if (acc) begin
                modelQ.push_back(ins);
                if (isIllegal(ins) && modelCnt < 255) modelCnt++;
            end
        end
        #1;
        compareModel();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'h0);
        checkOutput({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'h1);
        checkOutput({tag, "_imm"}, bus.imm, 32'h0);
        checkOutput({tag, "_imm_sel"}, {30'b0, bus.imm_sel}, 32'h0);
        checkOutput({tag, "_opcode"}, {27'b0, bus.opcode_out}, 32'h0);
        checkOutput({tag, "_illegal"}, {31'b0, bus.illegal}, 32'h0);
        checkOutput({tag, "_cnt"}, {24'b0, illegal_cnt}, 32'h0);
    endtask

    initial begin
        logic [31:0] ins;
        rst           = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst = 1'b1;

        // Extend-15 and Extend-19 vectors
        applyStimulus(1'b1, {5'b00001, 27'h7FFFFFF}, 1'b1, 1'b0);
        checkOutput("ext15_imm", bus.imm, 32'h00007FFF);
        checkOutput("ext15_sel", {30'b0, bus.imm_sel}, 32'h0);
        checkOutput("ext15_valid", {31'b0, bus.out_valid}, 32'h1);
        applyStimulus(1'b1, {5'b01010, 27'h4000123}, 1'b1, 1'b0);
        checkOutput("ext19_imm", bus.imm, 32'h00040001);
        checkOutput("ext19_sel", {30'b0, bus.imm_sel}, 32'h1);
        checkOutput("ext19_opc", {27'b0, bus.opcode_out}, 32'h0A);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: three offers, two taken, then drain in order
        applyStimulus(1'b1, {5'b10010, 27'h1234567}, 1'b0, 1'b0);
        applyStimulus(1'b1, {5'b00111, 27'h7654321}, 1'b0, 1'b0);
        applyStimulus(1'b1, {5'b01100, 27'h5555555}, 1'b0, 1'b0);
        checkOutput("bp_in_ready", {31'b0, bus.in_ready}, 32'h0);
        checkOutput("bp_head_opc", {27'b0, bus.opcode_out}, 32'h12);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_second_opc", {27'b0, bus.opcode_out}, 32'h07);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_drained_ready", {31'b0, bus.in_ready}, 32'h1);

        // Illegal opcode and counter saturation
        applyStimulus(1'b1, {5'b11101, 27'h1}, 1'b0, 1'b0);
        checkOutput("ill_flag", {31'b0, bus.illegal}, 32'h1);
        checkOutput("ill_imm", bus.imm, 32'h0);
        checkOutput("ill_cnt1", {24'b0, illegal_cnt}, 32'h1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, {5'b11100 | 5'(i % 4), 27'(i)}, 1'b1, 1'b0);
        end
        checkOutput("ill_cnt_sat", {24'b0, illegal_cnt}, 32'hFF);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush in TWO with a simultaneous offer, and in ONE where the offer would be taken
        applyStimulus(1'b1, {5'b00010, 27'h0ABCDEF}, 1'b0, 1'b0);
        applyStimulus(1'b1, {5'b00011, 27'h0FEDCBA}, 1'b0, 1'b0);
        applyStimulus(1'b1, {5'b11000, 27'h3333333}, 1'b0, 1'b1);
        checkOutput("flush_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("flush_ready", {31'b0, bus.in_ready}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, {5'b01000, 27'h1111111}, 1'b0, 1'b0);
        applyStimulus(1'b1, {5'b11110, 27'h2222222}, 1'b1, 1'b1);
        checkOutput("flush1_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("flush1_cnt", {24'b0, illegal_cnt}, 32'hFF);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between clock edges while holding one entry
        applyStimulus(1'b1, {5'b10001, 27'h7000000}, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkResetValues("async_rst");
        modelQ.delete();
        modelCnt = 0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, {5'b11011, 27'h6543210}, 1'b0, 1'b0);
        checkOutput("post_rst_valid", {31'b0, bus.out_valid}, 32'h1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            applyStimulus(($urandom_range(0, 9) < 7), ins,
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
